tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one serial transmitter between N_REQ packet sources (router output queues).
- Accepts a 55-bit packet from the winning requester and drives the transmitter's TX_Data / TX_Data_Valid handshake.
- Tracks the transmitter's TX_Ready to detect launch and completion, then reports completion to the owner.
- Sits between the router switch logic and the transmitter, all on the serial clock domain.

---
 rtl/tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// Round-robin owner of one serial transmitter shared by N_REQ packet queues.
// Grants a packet, launches it on the TX handshake and reports completion.
module tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_W     = 55,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    Clk_S,
  input  logic                    Rst_n,
  input  logic [N_REQ-1:0]        Req,
  input  logic [N_REQ*DATA_W-1:0] Req_Data,
  output logic [N_REQ-1:0]        Grant,
  output logic [N_REQ-1:0]        Done,
  output logic                    Busy,
  output logic                    Err,
  input  logic                    TX_Ready,
  output logic [DATA_W-1:0]       TX_Data,
  output logic                    TX_Data_Valid
);

  localparam int PW = $clog2(N_REQ);
  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [GW-1:0] GAP_LD  = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    SEND
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]     rr_ptr, rr_nx;
  logic [PW-1:0]     owner, owner_nx;
  logic [GW-1:0]     gap_cnt, gap_nx;
  logic [TW-1:0]     to_cnt, to_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              valid_q, valid_nx;
  logic              err_q, err_nx;

  logic [PW-1:0]     win;
  logic              win_ok;
  logic [N_REQ-1:0]  grant, done;
  logic              fin;

  // scan downward so the candidate nearest rr_ptr+1 is the last one kept
  always_comb begin
    int            idx;
    logic [PW-1:0] ix;
    win    = '0;
    win_ok = 1'b0;
    idx    = 0;
    ix     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      ix  = idx[PW-1:0];
      if (Req[ix]) begin
        win    = ix;
        win_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    owner_nx = owner;
    gap_nx   = gap_cnt;
    to_nx    = to_cnt;
    data_nx  = data_q;
    valid_nx = valid_q;
    err_nx   = err_q;
    grant    = '0;
    done     = '0;
    fin      = 1'b0;

    unique case (state)
      IDLE: begin
        valid_nx = 1'b0;
        if (gap_cnt != '0) begin
          gap_nx = gap_cnt - 1'b1;
        end else if (TX_Ready && win_ok) begin
          grant[win] = 1'b1;
          owner_nx   = win;
          data_nx    =
            Req_Data[int'(win)*DATA_W +: DATA_W];
          valid_nx   = 1'b1;
          to_nx      = '0;
          state_nx   = LAUNCH;
        end
      end
      LAUNCH: begin
        to_nx = to_cnt + 1'b1;
        if (!TX_Ready) begin
          valid_nx = 1'b0;
          to_nx    = '0;
          state_nx = SEND;
        end else if (to_cnt == TO_LAST) begin
          fin    = 1'b1;
          err_nx = 1'b1;
        end
      end
      SEND: begin
        to_nx = to_cnt + 1'b1;
        if (TX_Ready) begin
          fin = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          fin    = 1'b1;
          err_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    // normal completion and timeout abort release the owner the same way
    if (fin) begin
      done[owner] = 1'b1;
      rr_nx       = owner;
      gap_nx      = GAP_LD;
      valid_nx    = 1'b0;
      state_nx    = IDLE;
    end
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      rr_ptr  <= PTR_RST;
      owner   <= '0;
      gap_cnt <= '0;
      to_cnt  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_nx;
      owner   <= owner_nx;
      gap_cnt <= gap_nx;
      to_cnt  <= to_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      err_q   <= err_nx;
    end
  end

  // pulses are combinational, so hold them off while reset is asserted
  assign Grant         = Rst_n ? grant : '0;
  assign Done          = Rst_n ? done : '0;
  assign Busy          = (state != IDLE);
  assign Err           = err_q;
  assign TX_Data       = data_q;
  assign TX_Data_Valid = valid_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: scoreboarded grants on a default instance,
// timeout and mid-packet reset on a TIMEOUT=16 instance.
module tb_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 55;
  localparam int GAP = 2;
  localparam int PKT = 20;

  typedef struct {
    logic [N-1:0] g;
    logic [W-1:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, req_t;
  logic [N*W-1:0] rdata;
  logic         tx_ready, rdy_t;
  logic [N-1:0] g, d, gt, dt;
  logic         busy, err, txv;
  logic         busyt, errt, txvt;
  logic [W-1:0] txd, txdt;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   done_cyc = 0;
  bit   have_done = 0;
  bit   auto_tx = 0;
  logic [N-1:0] owner = '0;

  tx_arbiter u_dut (
    .Clk_S(clk), .Rst_n(rst_n), .Req(req),
    .Req_Data(rdata), .Grant(g), .Done(d),
    .Busy(busy), .Err(err), .TX_Ready(tx_ready),
    .TX_Data(txd), .TX_Data_Valid(txv)
  );

  tx_arbiter #(.TIMEOUT(16)) u_to (
    .Clk_S(clk), .Rst_n(rst_n), .Req(req_t),
    .Req_Data(rdata), .Grant(gt), .Done(dt),
    .Busy(busyt), .Err(errt), .TX_Ready(rdy_t),
    .TX_Data(txdt), .TX_Data_Valid(txvt)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] v);
    logic [N-1:0] oh;
    oh = 4'b0001 << i;
    rdata[i*W +: W] = v;
    sb.push_back('{g: oh, d: v});
  endtask

  task automatic drain(input int lim);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < lim);
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (d == '0 && n < lim);
    chk("done_wait", d != '0, 1);
  endtask

  task automatic wait_gt(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gt == '0 && n < lim);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    have_done = 0;
  endtask

  // transmitter: accepts valid while ready, then is busy PKT cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (auto_tx && txv && tx_ready) begin
      tx_ready = 1'b0;
      repeat (PKT) @(posedge clk);
      #1 tx_ready = 1'b1;
    end
  end

  // scoreboard monitor for the default instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (g != '0) begin
        if (sb.size() == 0) begin
          chk("grant_unexp", g, '0);
        end else begin
          e = sb.pop_front();
          chk("grant", g, e.g);
          if (have_done)
            chk("gap", cyc - done_cyc, GAP + 1);
          have_done = 0;
          owner = g;
          @(negedge clk);
          chk("tx_data", txd, e.d);
          chk("tx_valid", txv, 1);
        end
      end
      if (d != '0) begin
        chk("done", d, owner);
        have_done = 1;
        done_cyc  = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v0, v3, vt;
    int early;
    rst_n = 1'b0; req = '0; req_t = '0; rdata = '0;
    tx_ready = 1'b1; rdy_t = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_grant", g, 0);
    chk("rst_done", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_txd", txd, 0);
    chk("rst_txv", txv, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    push(1, 55'h0AB_CDEF_1234);
    req = 4'b0010;
    drain(50);
    req = '0;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("busy_launch", busy, 1);
    @(negedge clk);
    chk("valid_fall", txv, 0);
    repeat (3) @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    chk("done1", d, 4'b0010);
    @(negedge clk);
    chk("idle_busy", busy, 0);

    do_reset();
    auto_tx = 1;
    v0 = {$urandom, $urandom};
    push(0, v0);
    for (int i = 1; i < N; i++)
      push(i, {$urandom, $urandom});
    push(0, v0);
    req = 4'b1111;
    drain(500);
    req = '0;
    wait_done(100);

    @(posedge clk);
    #1;
    v3 = {$urandom, $urandom};
    push(3, v3);
    req = 4'b1000;
    drain(100);
    req = '0;
    wait_done(100);
    @(posedge clk);
    #1;
    push(0, {$urandom, $urandom});
    push(3, {$urandom, $urandom});
    req = 4'b1001;
    drain(200);
    req = '0;
    wait_done(100);

    @(posedge clk);
    #1;
    auto_tx = 0;
    tx_ready = 1'b0;
    have_done = 0;
    repeat (5) @(posedge clk);
    #1;
    push(0, {$urandom, $urandom});
    req = 4'b0001;
    repeat (4) @(negedge clk);
    chk("nr_grant", g, 0);
    chk("nr_busy", busy, 0);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    chk("nr_go", g, 4'b0001);
    auto_tx = 1;
    @(posedge clk);
    #1 req = '0;
    wait_done(100);
    @(posedge clk);
    #1 auto_tx = 0;

    vt = {$urandom, $urandom};
    rdata[0 +: W] = vt;
    do_reset();
    req_t = 4'b0001;
    @(negedge clk);
    chk("to_grant", gt, 4'b0001);
    @(posedge clk);
    #1 req_t = '0;
    early = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (dt != '0 || errt) early++;
    end
    chk("to_early", early, 0);
    @(negedge clk);
    chk("to_done", dt, 4'b0001);
    chk("to_err_pre", errt, 0);
    @(negedge clk);
    chk("to_err", errt, 1);
    chk("to_valid", txvt, 0);
    chk("to_data_kept", txdt, vt);
    chk("to_busy", busyt, 0);

    @(posedge clk);
    #1 req_t = 4'b0010;
    wait_gt(20);
    chk("to_g2", gt, 4'b0010);
    @(posedge clk);
    #1 req_t = '0;
    rdy_t = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy_t = 1'b1;
    @(negedge clk);
    chk("to_done2", dt, 4'b0010);
    chk("err_sticky", errt, 1);

    @(posedge clk);
    #1 req_t = 4'b0100;
    wait_gt(20);
    chk("to_g3", gt, 4'b0100);
    @(posedge clk);
    #1 req_t = '0;
    rdy_t = 1'b0;
    repeat (4) @(negedge clk);
    chk("send_busy", busyt, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", txvt, 0);
    chk("ar_busy", busyt, 0);
    chk("ar_err", errt, 0);
    chk("ar_done", dt, 0);
    rdy_t = 1'b1;
    early = 0;
    repeat (3) begin
      @(negedge clk);
      if (dt != '0) early++;
    end
    chk("ar_no_done", early, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_t = 4'b1111;
    @(negedge clk);
    chk("ar_first", gt, 4'b0001);
    @(posedge clk);
    #1 req_t = '0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
